serial_adder_n: RTL and testbench

//  Parametrised multi-cycle adder/subtractor built from a DIGIT-bit ripple slice.

---
 rtl/serial_adder_n.sv | 100 ++++++++++
 tb/tb_serial_adder_n.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: a DIGIT-bit ripple slice adds two WIDTH-bit
// operands over WIDTH/DIGIT clocks and registers sum, carry-out and overflow.
module serial_adder_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic             msb_cin;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    always_comb begin
        slice   = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // Carry into the top bit of this digit, recovered from its sum bit.
        msb_cin = slice[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
    end

    // Result digits enter the top of the A register as operand digits leave
    // the bottom, so after STEPS shifts it holds the complete sum.
    if (DIGIT == WIDTH) begin : g_one_step
        assign a_next = slice[DIGIT-1:0];
        assign b_next = '0;
    end else begin : g_multi_step
        assign a_next = {slice[DIGIT-1:0], a_sr[WIDTH-1:DIGIT]};
        assign b_next = {{DIGIT{1'b0}}, b_sr[WIDTH-1:DIGIT]};
    end

    // Handshake: start is accepted on any edge where busy=0; busy stays high
    // for STEPS cycles, then done pulses once as the outputs update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_next;
                    b_sr  <= b_next;
                    carry <= slice[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= a_next;
                        cout     <= slice[DIGIT];
                        overflow <= slice[DIGIT] ^ msb_cin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: three WIDTH=8 instances (DIGIT=1,2,8) share one
// stimulus stream; each is checked cycle by cycle against a transaction model.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;

    logic       busy_w [3];
    logic       done_w [3];
    logic       cout_w [3];
    logic       ov_w   [3];
    logic [7:0] sum_w  [3];

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .overflow(ov_w[0])
    );
    serial_adder_n #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .overflow(ov_w[1])
    );
    serial_adder_n #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .overflow(ov_w[2])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected entry: {accept edge[15:0], overflow, cout, sum[7:0]}
    logic [25:0] exp_q [3][$];
    logic [9:0]  hold [3];
    int          next_free [3];

    typedef struct {
        logic       s;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [7:0] es;
        logic       eco;
        logic       eov;
    } vec_t;

    vec_t vecs [11];

    function automatic int steps_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 4 : 1;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [9:0] model(input logic s, input logic [7:0] x,
                                         input logic [7:0] y, input logic c);
        int   u;
        int   sv;
        logic co;
        logic ov;
        if (!s) begin
            u  = int'(x) + int'(y) + int'(c);
            sv = int'($signed(x)) + int'($signed(y)) + int'(c);
            co = (u > 255);
        end else begin
            u  = int'(x) - int'(y);
            sv = int'($signed(x)) - int'($signed(y));
            co = (x >= y);
        end
        ov = (sv > 127) || (sv < -128);
        return {ov, co, u[7:0]};
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d",
                     name, d, act, exp, cyc);
        end
    endtask

    task automatic flush();
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            hold[d]      = '0;
            next_free[d] = 0;
        end
    endtask

    // Called with start=1 being driven: records the op for every instance that
    // is idle at the coming edge.
    task automatic push_all(input logic [9:0] e);
        for (int d = 0; d < 3; d++) begin
            int acc;
            acc = cyc + 1;
            if (acc >= next_free[d]) begin
                exp_q[d].push_back({acc[15:0], e});
                next_free[d] = acc + steps_of(d) + 1;
            end
        end
    endtask

    task automatic issue(input logic s, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic [9:0] e);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        cin   = c;
        push_all(e);
        @(negedge clk);
        start = 1'b0;
        sub   = 1'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic mon(input int d);
        logic        eb;
        logic        ed;
        int          acc;
        logic [25:0] f;
        eb = 1'b0;
        ed = 1'b0;
        f  = '0;
        if (exp_q[d].size() > 0) begin
            f   = exp_q[d][0];
            acc = int'(f[25:10]);
            eb  = (cyc >= acc) && (cyc < acc + steps_of(d));
            ed  = (cyc == acc + steps_of(d));
        end
        check("busy", d, 32'(busy_w[d]), 32'(eb));
        check("done", d, 32'(done_w[d]), 32'(ed));
        if (ed) begin
            hold[d] = f[9:0];
            void'(exp_q[d].pop_front());
        end
        check("sum", d, 32'(sum_w[d]), 32'(hold[d][7:0]));
        check("cout", d, 32'(cout_w[d]), 32'(hold[d][8]));
        check("overflow", d, 32'(ov_w[d]), 32'(hold[d][9]));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) mon(d);
        end
    end

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            check({tag, "_busy"}, d, 32'(busy_w[d]), 32'd0);
            check({tag, "_done"}, d, 32'(done_w[d]), 32'd0);
            check({tag, "_sum"}, d, 32'(sum_w[d]), 32'd0);
            check({tag, "_cout"}, d, 32'(cout_w[d]), 32'd0);
            check({tag, "_ovf"}, d, 32'(ov_w[d]), 32'd0);
        end
    endtask

    initial begin
        logic       s;
        logic       c;
        logic [7:0] x;
        logic [7:0] y;

        vecs[0]  = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        flush();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, each run to completion on all instances.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].c,
                  {vecs[i].eov, vecs[i].eco, vecs[i].es});
            repeat (10) @(negedge clk);
        end

        // Random ops with random gaps, so some starts land while busy.
        repeat (40) begin
            s = 1'($urandom);
            c = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            issue(s, x, y, c, model(s, x, y, c));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        // start held high with operands changing every cycle.
        repeat (30) begin
            s     = 1'($urandom);
            c     = 1'($urandom);
            x     = 8'($urandom);
            y     = 8'($urandom);
            start = 1'b1;
            sub   = s;
            a     = x;
            b     = y;
            cin   = c;
            push_all(model(s, x, y, c));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        // New start presented in the DIGIT=1 instance's done cycle.
        issue(1'b0, 8'h12, 8'h34, 1'b0, model(1'b0, 8'h12, 8'h34, 1'b0));
        repeat (8) @(negedge clk);
        issue(1'b1, 8'h55, 8'h0F, 1'b0, model(1'b1, 8'h55, 8'h0F, 1'b0));
        repeat (12) @(negedge clk);

        // Asynchronous reset three cycles into an operation.
        issue(1'b0, 8'h5A, 8'h33, 1'b0, model(1'b0, 8'h5A, 8'h33, 1'b0));
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        flush();
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 8'hA5, 8'h3C, 1'b1, model(1'b0, 8'hA5, 8'h3C, 1'b1));
        repeat (12) @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            check("pending_ops", d, 32'(exp_q[d].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
